sysref_lock_ctrl: RTL and testbench

//  Supervises the PL-captured SYSREF (sysref_adc) in the pl_clk domain and qualifies it for use.

---
 rtl/sysref_lock_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_sysref_lock_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysref_lock_ctrl.sv
// sysref_lock_ctrl: supervises the PL-captured SYSREF on pl_clk.
// It measures the SYSREF period, declares lock after LOCK_COUNT consecutive
// in-tolerance periods, and issues one SYSREF-aligned sync_pulse per request.
//
// Optional build macro: SYSREF_WATCHDOG_EN. When it is defined, a missing
// SYSREF while LOCKED is flagged on err_lost as soon as cnt reaches
// exp_period+TOL+1. When it is undefined, err_lost is tied to 0.
//
// Ports:
//   pl_clk      PL clock (same clock as the SYSREF capture flop)
//   pl_rst      synchronous, active-high reset
//   sysref_adc  SYSREF, already registered on pl_clk
//   exp_period  expected SYSREF period in pl_clk cycles, sampled on arm
//   arm         one-cycle pulse that starts acquisition
//   disarm      one-cycle pulse that returns to IDLE
//   sync_req    one-cycle pulse that requests one aligned sync_pulse
//   locked      high in LOCKED only
//   sync_pulse  one-cycle strobe in the cycle after a serviced SYSREF edge
//   period_meas last measured period
//   edge_count  SYSREF rising edges seen since arm (wraps)
//   err_period  sticky: period mismatch while LOCKED
//   err_lost    sticky: SYSREF missing while LOCKED (watchdog build only)
module sysref_lock_ctrl #(
   parameter int unsigned PERIOD_W   = 16,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned TOL        = 1
) (
   input  logic                pl_clk,
   input  logic                pl_rst,
   input  logic                sysref_adc,
   input  logic [PERIOD_W-1:0] exp_period,
   input  logic                arm,
   input  logic                disarm,
   input  logic                sync_req,
   output logic                locked,
   output logic                sync_pulse,
   output logic [PERIOD_W-1:0] period_meas,
   output logic [15:0]         edge_count,
   output logic                err_period,
   output logic                err_lost
);

   localparam int unsigned         MC_W    = 4;
   localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
   localparam logic [PERIOD_W-1:0] TOL_V   = PERIOD_W'(TOL);
   localparam logic [MC_W-1:0]     LOCK_V  = MC_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                sr_d;
   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] exp_q;
   logic [MC_W-1:0]     match_cnt;
   logic                first;
   logic                pend;

   logic                sr_edge;
   logic [PERIOD_W-1:0] diff;
   logic                in_tol;
   logic                arm_go;
   logic                wd_trip;
   logic                service;

   logic [PERIOD_W-1:0] cnt_nxt;
   logic [PERIOD_W-1:0] exp_nxt;
   logic [MC_W-1:0]     match_cnt_nxt;
   logic                first_nxt;
   logic                pend_nxt;
   logic                sync_pulse_nxt;
   logic                err_period_nxt;
   logic [PERIOD_W-1:0] period_meas_nxt;
   logic [15:0]         edge_count_nxt;

   // Rising edge of the captured SYSREF and the tolerance check on the measurement
   assign sr_edge = sysref_adc & ~sr_d;
   assign diff    = (cnt >= exp_q) ? (cnt - exp_q) : (exp_q - cnt);
   assign in_tol  = (cnt != CNT_MAX) && (diff <= TOL_V);

   // Arm is only honoured from IDLE/ERROR, with a usable period, and loses to disarm
   assign arm_go = arm && !disarm && (exp_period >= PERIOD_W'(2)) &&
                   ((state == ST_IDLE) || (state == ST_ERROR));

`ifdef SYSREF_WATCHDOG_EN
   localparam int unsigned WD_W = PERIOD_W + 2;
   logic [WD_W-1:0] wd_limit;
   logic            err_lost_nxt;

   // Extra bits so exp_period+TOL+1 cannot wrap
   assign wd_limit = WD_W'(exp_q) + WD_W'(TOL) + WD_W'(1);
   assign wd_trip  = (state == ST_LOCKED) && !sr_edge && (WD_W'(cnt) >= wd_limit);
`else
   assign wd_trip  = 1'b0;
   assign err_lost = 1'b0;
`endif

   // A request is serviced on an in-tolerance edge that keeps us LOCKED
   assign service = (state == ST_LOCKED) && (state_nxt == ST_LOCKED) && sr_edge && pend;

   // State register
   always_ff @(posedge pl_clk) begin
      if (pl_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; disarm overrides everything
   always_comb begin
      state_nxt = state;
      if (disarm) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm_go) state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               if (sr_edge && !first && in_tol && ((match_cnt + MC_W'(1)) == LOCK_V))
                  state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
               if ((sr_edge && !in_tol) || wd_trip) state_nxt = ST_ERROR;
            end
            ST_ERROR: begin
               if (arm_go) state_nxt = ST_ACQUIRE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      cnt_nxt         = sr_edge ? PERIOD_W'(1) :
                        ((cnt == CNT_MAX) ? cnt : (cnt + PERIOD_W'(1)));
      exp_nxt         = exp_q;
      match_cnt_nxt   = match_cnt;
      first_nxt       = first;
      pend_nxt        = pend;
      sync_pulse_nxt  = 1'b0;
      err_period_nxt  = err_period;
      period_meas_nxt = period_meas;
      edge_count_nxt  = edge_count;
`ifdef SYSREF_WATCHDOG_EN
      err_lost_nxt    = err_lost;
`endif

      if (sr_edge && (state != ST_IDLE)) begin
         period_meas_nxt = cnt;
         edge_count_nxt  = edge_count + 16'd1;
      end

      if (arm_go) begin
         exp_nxt        = exp_period;
         match_cnt_nxt  = '0;
         first_nxt      = 1'b1;
         edge_count_nxt = '0;
         err_period_nxt = 1'b0;
`ifdef SYSREF_WATCHDOG_EN
         err_lost_nxt   = 1'b0;
`endif
      end

      // First edge after arm only starts timing
      if ((state == ST_ACQUIRE) && sr_edge) begin
         if (first) begin
            first_nxt = 1'b0;
         end else if (in_tol) begin
            match_cnt_nxt = match_cnt + MC_W'(1);
         end else begin
            match_cnt_nxt = '0;
         end
      end

      if ((state == ST_LOCKED) && !disarm && sr_edge && !in_tol) err_period_nxt = 1'b1;
`ifdef SYSREF_WATCHDOG_EN
      if (!disarm && wd_trip) err_lost_nxt = 1'b1;
`endif

      // A request arriving with a serviced edge is kept for the next edge
      if (disarm || ((state == ST_LOCKED) && (state_nxt != ST_LOCKED))) begin
         pend_nxt = 1'b0;
      end else if (service) begin
         pend_nxt       = sync_req;
         sync_pulse_nxt = 1'b1;
      end else if (sync_req) begin
         pend_nxt = 1'b1;
      end
   end

   // Datapath and output registers
   always_ff @(posedge pl_clk) begin
      if (pl_rst) begin
         sr_d        <= 1'b0;
         cnt         <= '0;
         exp_q       <= '0;
         match_cnt   <= '0;
         first       <= 1'b0;
         pend        <= 1'b0;
         locked      <= 1'b0;
         sync_pulse  <= 1'b0;
         period_meas <= '0;
         edge_count  <= '0;
         err_period  <= 1'b0;
`ifdef SYSREF_WATCHDOG_EN
         err_lost    <= 1'b0;
`endif
      end else begin
         sr_d        <= sysref_adc;
         cnt         <= cnt_nxt;
         exp_q       <= exp_nxt;
         match_cnt   <= match_cnt_nxt;
         first       <= first_nxt;
         pend        <= pend_nxt;
         locked      <= (state_nxt == ST_LOCKED);
         sync_pulse  <= sync_pulse_nxt;
         period_meas <= period_meas_nxt;
         edge_count  <= edge_count_nxt;
         err_period  <= err_period_nxt;
`ifdef SYSREF_WATCHDOG_EN
         err_lost    <= err_lost_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_sysref_lock_ctrl.sv
// Bench for sysref_lock_ctrl: directed scenarios plus randomized SYSREF
// trains, checked every cycle against an edge/rule-level reference model.
module tb_sysref_lock_ctrl;

   localparam int TOL  = 1;
   localparam int LOCK = 4;
   localparam int MAXV = 65535;
   localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_ERR = 3;

   logic        pl_clk;
   logic        pl_rst;
   logic        sysref_adc;
   logic [15:0] exp_period;
   logic        arm;
   logic        disarm;
   logic        sync_req;
   logic        locked;
   logic        sync_pulse;
   logic [15:0] period_meas;
   logic [15:0] edge_count;
   logic        err_period;
   logic        err_lost;

   int total;
   int bad;
   int hi_left;
   int pulse_seen;

   // Reference model state
   int m_mode, m_since, m_exp, m_good, m_pm, m_ec;
   int m_first, m_pend, m_prev, m_lk, m_sp, m_ep, m_el;

   sysref_lock_ctrl #(.PERIOD_W(16), .LOCK_COUNT(LOCK), .TOL(TOL)) dut (
      .pl_clk      (pl_clk),
      .pl_rst      (pl_rst),
      .sysref_adc  (sysref_adc),
      .exp_period  (exp_period),
      .arm         (arm),
      .disarm      (disarm),
      .sync_req    (sync_req),
      .locked      (locked),
      .sync_pulse  (sync_pulse),
      .period_meas (period_meas),
      .edge_count  (edge_count),
      .err_period  (err_period),
      .err_lost    (err_lost)
   );

   initial pl_clk = 1'b0;
   always #5 pl_clk = ~pl_clk;

   initial begin
      #2ms;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   // Applies the rules to the inputs present before the coming clock edge
   task automatic model_step();
      int meas, nmode, r, in_tol, go, serviced;
      if (pl_rst) begin
         m_mode = M_IDLE; m_since = 0; m_exp = 0; m_good = 0; m_pm = 0; m_ec = 0;
         m_first = 0; m_pend = 0; m_prev = 0; m_lk = 0; m_sp = 0; m_ep = 0; m_el = 0;
         return;
      end
      r = (sysref_adc && !m_prev) ? 1 : 0;
      m_prev = sysref_adc ? 1 : 0;
      meas = m_since;
      in_tol = (meas != MAXV && meas <= m_exp + TOL && meas + TOL >= m_exp) ? 1 : 0;
      m_since = r ? 1 : ((m_since == MAXV) ? MAXV : m_since + 1);
      go = (arm && !disarm && exp_period >= 2 && (m_mode == M_IDLE || m_mode == M_ERR)) ? 1 : 0;
      m_sp = 0;
      serviced = 0;
      if (r && m_mode != M_IDLE) begin
         m_pm = meas;
         m_ec = (m_ec + 1) % 65536;
      end
      nmode = m_mode;
      if (go) begin
         m_exp = int'(exp_period); m_good = 0; m_ec = 0; m_ep = 0; m_el = 0; m_first = 1;
         nmode = M_ACQ;
      end
      if (disarm) begin
         nmode = M_IDLE;
      end else if (m_mode == M_ACQ && r) begin
         if (m_first) m_first = 0;
         else if (in_tol) begin
            m_good++;
            if (m_good == LOCK) nmode = M_LOCK;
         end else m_good = 0;
      end else if (m_mode == M_LOCK) begin
         if (r && !in_tol) begin
            nmode = M_ERR; m_ep = 1;
         end else if (r && m_pend) begin
            m_sp = 1; serviced = 1;
         end
`ifdef SYSREF_WATCHDOG_EN
         else if (!r && meas >= m_exp + TOL + 1) begin
            nmode = M_ERR; m_el = 1;
         end
`endif
      end
      if (disarm || (m_mode == M_LOCK && nmode != M_LOCK)) m_pend = 0;
      else if (serviced) m_pend = sync_req ? 1 : 0;
      else if (sync_req) m_pend = 1;
      m_mode = nmode;
      m_lk = (nmode == M_LOCK) ? 1 : 0;
   endtask

   // One clock: model, wait past the edge, compare every output
   task automatic tick();
      model_step();
      @(negedge pl_clk);
      chk("locked",      32'(locked),      32'(m_lk));
      chk("sync_pulse",  32'(sync_pulse),  32'(m_sp));
      chk("period_meas", 32'(period_meas), 32'(m_pm));
      chk("edge_count",  32'(edge_count),  32'(m_ec));
      chk("err_period",  32'(err_period),  32'(m_ep));
      chk("err_lost",    32'(err_lost),    32'(m_el));
      if (sync_pulse === 1'b1) pulse_seen++;
      if (hi_left > 0) begin
         hi_left--;
         if (hi_left == 0) sysref_adc = 1'b0;
      end
   endtask

   // gap cycles after the previous edge, raise SYSREF for width cycles;
   // bit i of req_mask drives sync_req on cycle i (bit gap-1 is the edge cycle)
   task automatic gap_edge(input int gap, input int width, input int req_mask);
      for (int i = 0; i < gap; i++) begin
         sync_req = req_mask[i];
         if (i == gap - 1) begin
            sysref_adc = 1'b1;
            hi_left    = width;
         end
         tick();
      end
      sync_req = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   task automatic do_disarm();
      disarm = 1'b1; tick(); disarm = 1'b0;
   endtask

   initial begin
      int g, w, mask, ex, seen;
      total = 0; bad = 0; hi_left = 0; pulse_seen = 0;
      pl_rst = 1'b1; sysref_adc = 1'b0; exp_period = '0;
      arm = 1'b0; disarm = 1'b0; sync_req = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 6; i++) begin
         arm = 1'($urandom); disarm = 1'($urandom); sync_req = 1'($urandom);
         sysref_adc = 1'($urandom); exp_period = 16'($urandom);
         tick();
      end
      chk("rst_locked", 32'(locked), 0);
      chk("rst_ec", 32'(edge_count), 0);
      chk("rst_pm", 32'(period_meas), 0);
      pl_rst = 1'b0; arm = 1'b0; disarm = 1'b0; sync_req = 1'b0; sysref_adc = 1'b0;
      exp_period = 16'd8;
      tick();
      repeat (3) gap_edge(5, 1, 0);
      chk("idle_ec", 32'(edge_count), 0);

      // arm with exp_period below 2 is ignored
      exp_period = 16'd1;
      do_arm();
      repeat (3) gap_edge(6, 2, 0);
      chk("arm_lt2_ec", 32'(edge_count), 0);
      chk("arm_lt2_locked", 32'(locked), 0);

      // Acquire and lock at period 8
      exp_period = 16'd8;
      do_arm();
      gap_edge(6, 1, 0);
      for (int k = 2; k <= 5; k++) begin
         gap_edge(8, 1, 0);
         if (k == 4) chk("lock_edge4", 32'(locked), 0);
      end
      chk("lock_edge5", 32'(locked), 1);
      chk("lock_pm", 32'(period_meas), 8);
      chk("lock_ec", 32'(edge_count), 5);

      // Tolerance boundaries keep lock
      gap_edge(9, 1, 0);
      chk("p9_locked", 32'(locked), 1);
      chk("p9_pm", 32'(period_meas), 9);
      gap_edge(7, 1, 0);
      chk("p7_locked", 32'(locked), 1);
      chk("p7_pm", 32'(period_meas), 7);

      // Two requests before an edge -> one pulse; request on a serviced edge is held
      pulse_seen = 0;
      gap_edge(8, 1, 32'h24);
      chk("sync_a", 32'(sync_pulse), 1);
      gap_edge(8, 1, 32'h84);
      chk("sync_b", 32'(sync_pulse), 1);
      gap_edge(8, 1, 0);
      chk("sync_c", 32'(sync_pulse), 1);
      gap_edge(8, 1, 0);
      chk("sync_d", 32'(sync_pulse), 0);
      chk("sync_count", 32'(pulse_seen), 3);

      // Period 11 breaks lock
      gap_edge(11, 1, 0);
      chk("p11_locked", 32'(locked), 0);
      chk("p11_pm", 32'(period_meas), 11);
      chk("p11_ec", 32'(edge_count), 12);
`ifdef SYSREF_WATCHDOG_EN
      chk("p11_err_lost", 32'(err_lost), 1);
`else
      chk("p11_err_period", 32'(err_period), 1);
`endif

      // arm and disarm together -> IDLE, edges no longer counted
      arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
      repeat (2) gap_edge(8, 1, 0);
      chk("ad_ec", 32'(edge_count), 12);
      chk("ad_locked", 32'(locked), 0);

      // Reset during acquisition at the third edge
      do_arm();
      gap_edge(5, 1, 0);
      gap_edge(8, 1, 0);
      repeat (7) tick();
      sysref_adc = 1'b1; hi_left = 1; pl_rst = 1'b1;
      tick();
      pl_rst = 1'b0;
      chk("mrst_ec", 32'(edge_count), 0);
      chk("mrst_pm", 32'(period_meas), 0);
      chk("mrst_err", 32'(err_period), 0);
      do_arm();
      gap_edge(4, 1, 0);
      for (int k = 2; k <= 5; k++) begin
         gap_edge(8, 1, 0);
         if (k == 4) chk("relock_edge4", 32'(locked), 0);
      end
      chk("relock_edge5", 32'(locked), 1);
      chk("relock_ec", 32'(edge_count), 5);

      // SYSREF stops while locked
      seen = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (seen < 0 && err_lost === 1'b1) seen = i;
      end
`ifdef SYSREF_WATCHDOG_EN
      chk("wd_latency", 32'(seen), 10);
      chk("wd_locked", 32'(locked), 0);
`else
      chk("nowd_seen", 32'(seen), 32'hFFFF_FFFF);
      chk("nowd_locked", 32'(locked), 1);
`endif

      // Randomized SYSREF trains with random requests and occasional bad periods
      for (int round = 0; round < 6; round++) begin
         if ($urandom_range(0, 1) == 0 || round == 0) do_disarm();
         ex = int'($urandom_range(3, 20));
         exp_period = 16'(ex);
         do_arm();
         gap_edge(int'($urandom_range(2, 30)), 1, 0);
         for (int e = 0; e < 12; e++) begin
            if ($urandom_range(0, 7) == 0) g = ex + 2 + int'($urandom_range(0, 2));
            else g = ex - 1 + int'($urandom_range(0, 2));
            w = int'($urandom_range(1, (g - 1 < 3) ? g - 1 : 3));
            mask = int'($urandom & $urandom & $urandom);
            gap_edge(g, w, mask);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
